// File: rtl/i2c_uart_pkg.sv
// Shared ASCII constants, hex helper and reporter FSM encoding for the
// I2C status UART reporter.
package i2c_uart_pkg;

    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_O     = 8'h4F;
    localparam logic [7:0] CH_K     = 8'h4B;
    localparam logic [7:0] CH_N     = 8'h4E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOAD,
        ST_SEND,
        ST_ADVANCE,
        ST_FIN
    } rep_state_e;

    // Uppercase hex digit for a nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/i2c_status_uart_tx_if.sv
// Sequencer-facing status/done bundle plus the UART-side report outputs.
interface i2c_status_uart_tx_if #(
    parameter int unsigned NBYTES = 2,
    parameter int unsigned NTRANS = 2
);
    logic              done_i;
    logic [NBYTES-1:0] status_i [NTRANS];
    logic              tx_o;
    logic              busy_o;
    logic              sent_o;

    modport master (output done_i, output status_i,
                    input  tx_o,   input  busy_o, input sent_o);
    modport slave  (input  done_i, input  status_i,
                    output tx_o,   output busy_o, output sent_o);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. done_o fires three cycles before the stop bit ends so
// the caller can queue the next byte with no idle gap between frames.
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned DONE_IDX = 10 * BAUD_DIV - 4;

    logic [CNT_W-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_end_c;
    logic             frame_end_c;
    logic [31:0]      idx_c;

    always_comb begin
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idx_c       = 32'(bit_q) * BAUD_DIV + 32'(baud_q);
        baud_end_c  = (baud_q == CNT_W'(BAUD_DIV - 1));
        frame_end_c = busy_q && baud_end_c && (bit_q == 4'd9);

        if (busy_q) begin
            done_d = (idx_c == DONE_IDX);
            if (baud_end_c) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                    tx_d    = shift_q[1];
                end
            end else begin
                baud_d = baud_q + CNT_W'(1);
            end
        end

        // A start on the last stop-bit cycle chains the next frame seamlessly.
        if (start_i && (!busy_q || frame_end_c)) begin
            shift_d = {1'b1, data_i, 1'b0};
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/i2c_status_uart_tx.sv
// Captures the sequencer's ACK/NACK status on done and streams it as an ASCII
// report ("Tn:bits" lines plus an OK/NK summary) over an 8N1 UART line.
module i2c_status_uart_tx
    import i2c_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned NBYTES   = 2,
    parameter int unsigned NTRANS   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    i2c_status_uart_tx_if.slave   bus
);
    localparam int unsigned LW = $clog2(NTRANS + 1);
    localparam int unsigned CW = 4;

    rep_state_e        state_q, state_d;
    logic [NBYTES-1:0] snap_q [NTRANS];
    logic [NBYTES-1:0] snap_d [NTRANS];
    logic              nack_q, nack_d;
    logic [LW-1:0]     line_q, line_d;
    logic [CW-1:0]     char_q, char_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;

    logic              start_c;
    logic [7:0]        data_c;
    logic              last_c;
    logic              is_sum_c;
    logic              any_c;
    logic [NBYTES-1:0] sel_c;
    logic              ser_busy;
    logic              ser_done;

    // Any NACK in the incoming status vector decides the summary line.
    always_comb begin
        any_c = 1'b0;
        for (int unsigned t = 0; t < NTRANS; t++) begin
            any_c = any_c | (|bus.status_i[t]);
        end
    end

    // Character for the current (line, position); line NTRANS is the summary.
    always_comb begin
        sel_c    = '0;
        data_c   = CH_LF;
        is_sum_c = (32'(line_q) == NTRANS);
        for (int unsigned t = 0; t < NTRANS; t++) begin
            if (32'(line_q) == t) sel_c = snap_q[t];
        end
        if (is_sum_c) begin
            last_c = (char_q == CW'(3));
            case (char_q)
                CW'(0):  data_c = nack_q ? CH_N : CH_O;
                CW'(1):  data_c = CH_K;
                CW'(2):  data_c = CH_CR;
                default: data_c = CH_LF;
            endcase
        end else begin
            last_c = (32'(char_q) == 4 + NBYTES);
            if (char_q == CW'(0)) begin
                data_c = CH_T;
            end else if (char_q == CW'(1)) begin
                data_c = hex_ascii(4'(line_q));
            end else if (char_q == CW'(2)) begin
                data_c = CH_COLON;
            end else if (32'(char_q) == 3 + NBYTES) begin
                data_c = CH_CR;
            end else if (32'(char_q) == 4 + NBYTES) begin
                data_c = CH_LF;
            end else begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (32'(char_q) == 3 + NBYTES - 1 - b) data_c = sel_c[b] ? CH_ONE : CH_ZERO;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        nack_d  = nack_q;
        line_d  = line_q;
        char_d  = char_q;
        busy_d  = busy_q;
        sent_d  = 1'b0;
        start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.done_i) begin
                    snap_d  = bus.status_i;
                    nack_d  = any_c;
                    line_d  = '0;
                    char_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_LOAD;
            ST_LOAD: begin
                start_c = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (!last_c) begin
                    char_d  = char_q + CW'(1);
                    state_d = ST_LOAD;
                end else if (!is_sum_c) begin
                    char_d  = '0;
                    line_d  = line_q + LW'(1);
                    state_d = ST_LOAD;
                end else if (!ser_busy) begin
                    // Report is only "sent" once the final stop bit has left.
                    busy_d  = 1'b0;
                    sent_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            for (int unsigned t = 0; t < NTRANS; t++) snap_q[t] <= '0;
            nack_q  <= 1'b0;
            line_q  <= '0;
            char_q  <= '0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            nack_q  <= nack_d;
            line_q  <= line_d;
            char_q  <= char_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_ser (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_c),
        .data_i  (data_c),
        .tx_o    (bus.tx_o),
        .busy_o  (ser_busy),
        .done_o  (ser_done)
    );

    assign bus.busy_o = busy_q;
    assign bus.sent_o = sent_q;

endmodule

// File: tb/tb_i2c_status_uart_tx.sv
// Bench: two reporters (2x2 and 16x1 status) checked cycle-by-cycle against a
// queue of expected line levels built from the report text, plus a UART decoder.
module tb_i2c_status_uart_tx;

    localparam int unsigned B = 4;

    typedef struct {
        bit tx;
        bit busy;
        bit care;
        int off;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_status_uart_tx_if #(.NBYTES(2), .NTRANS(2))  ifa ();
    i2c_status_uart_tx_if #(.NBYTES(1), .NTRANS(16)) ifc ();

    i2c_status_uart_tx #(.BAUD_DIV(B), .NBYTES(2), .NTRANS(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa.slave));
    i2c_status_uart_tx #(.BAUD_DIV(B), .NBYTES(1), .NTRANS(16)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifc.slave));

    int   checks   = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qc[$];
    byte  rpt[$];
    byte  exp_a[$];
    byte  rx_q[$];
    int   sent_a = 0;
    int   sent_c = 0;
    bit   rx_first = 1'b0;
    time  fall_t = 0;
    time  done_t = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rx_str(input string nm, input string s);
        bit bad;
        checks++;
        bad = (rx_q.size() != s.len());
        for (int i = 0; i < rx_q.size() && i < s.len(); i++)
            if (rx_q[i] != byte'(s[i])) bad = 1'b1;
        if (bad) begin
            failures++;
            $display("FAIL %s: decoded %0d chars, want %0d chars '%s'", nm, rx_q.size(), s.len(), s);
        end
    endtask

    task automatic chk_bytes(input string nm, input byte act[$], input byte exp[$]);
        bit bad;
        checks++;
        bad = (act.size() != exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            if (act[i] != exp[i]) bad = 1'b1;
        if (bad) begin
            failures++;
            $display("FAIL %s: got %0d chars want %0d chars", nm, act.size(), exp.size());
        end
    endtask

    // Report text straight from the format rules.
    function automatic void build(input int nt, input int nb, input int st[16]);
        bit any = 1'b0;
        rpt.delete();
        for (int t = 0; t < nt; t++) begin
            rpt.push_back(byte'(8'h54));
            rpt.push_back(byte'(t < 10 ? 48 + t : 55 + t));
            rpt.push_back(byte'(8'h3A));
            for (int b = nb - 1; b >= 0; b--)
                rpt.push_back(byte'(((st[t] >> b) & 1) != 0 ? 8'h31 : 8'h30));
            rpt.push_back(byte'(13));
            rpt.push_back(byte'(10));
            if (st[t] != 0) any = 1'b1;
        end
        rpt.push_back(byte'(any ? 8'h4E : 8'h4F));
        rpt.push_back(byte'(8'h4B));
        rpt.push_back(byte'(13));
        rpt.push_back(byte'(10));
    endfunction

    task automatic add(input int which, input bit tx, input bit busy, input bit care,
                       input int off, input int lat);
        exp_t e;
        e = '{tx: tx, busy: busy, care: care, off: off, lat: lat};
        if (which == 0) qa.push_back(e); else qc.push_back(e);
    endtask

    // Expected line levels per cycle, offset 0 = cycle right after the done edge.
    task automatic push_exp(input int which);
        int lat = 2 + 10 * int'(B) * rpt.size();
        int off = 2;
        bit lvl;
        add(which, 1'b1, 1'b1, 1'b1, 0, lat);
        add(which, 1'b1, 1'b1, 1'b1, 1, lat);
        foreach (rpt[i]) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      lvl = 1'b0;
                else if (k == 9) lvl = 1'b1;
                else             lvl = rpt[i][k-1];
                for (int c = 0; c < int'(B); c++) begin
                    add(which, lvl, 1'b1, 1'b1, off, lat);
                    off++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            add(which, 1'b1, 1'b0, 1'b0, off, lat);
            off++;
        end
    endtask

    task automatic check_entry(input string nm, input bit have, input exp_t e,
                               input logic tx, input logic busy, input logic sent,
                               output int sc_inc);
        sc_inc = 0;
        if (have) begin
            chk({nm, "_tx"}, int'(tx), int'(e.tx));
            if (e.care) begin
                chk({nm, "_busy"}, int'(busy), int'(e.busy));
                chk({nm, "_sent_early"}, int'(sent), 0);
            end else if (sent === 1'b1) begin
                sc_inc = 1;
                chk({nm, "_sent_latency_ok"}, int'((e.off - e.lat) <= 2 && (e.lat - e.off) <= 2), 1);
                chk({nm, "_busy_at_sent"}, int'(busy), 0);
            end
        end else begin
            chk({nm, "_idle_tx"}, int'(tx), 1);
            chk({nm, "_idle_busy"}, int'(busy), 0);
            chk({nm, "_idle_sent"}, int'(sent), 0);
        end
    endtask

    // Single compare process against the model queues.
    initial begin
        exp_t e;
        bit   have;
        int   inc;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                have = (qa.size() != 0);
                if (have) e = qa.pop_front();
                check_entry("A", have, e, ifa.tx_o, ifa.busy_o, ifa.sent_o, inc);
                sent_a += inc;
                have = (qc.size() != 0);
                if (have) e = qc.pop_front();
                check_entry("C", have, e, ifc.tx_o, ifc.busy_o, ifc.sent_o, inc);
                sent_c += inc;
            end
        end
    end

    // UART decoder on DUT A, sampling mid-bit.
    initial begin
        bit  act = 1'b0;
        int  cnt = 0;
        byte sh = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (ifa.tx_o === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    sh  = 0;
                    if (rx_first) begin
                        fall_t   = $time;
                        rx_first = 1'b0;
                    end
                end
            end else begin
                cnt++;
                if (cnt % int'(B) == 2 && cnt / int'(B) >= 1 && cnt / int'(B) <= 8)
                    sh = {ifa.tx_o, sh[7:1]};
                if (cnt == 10 * int'(B) - 1) begin
                    act = 1'b0;
                    rx_q.push_back(sh);
                end
            end
        end
    end

    task automatic fire(input bit fa, input bit fc, input int sta[16], input int stc[16]);
        @(negedge clk);
        if (fa) begin
            ifa.done_i = 1'b1;
            for (int t = 0; t < 2; t++) ifa.status_i[t] = 2'(sta[t]);
            if (qa.size() == 0) rx_q.delete();
        end
        if (fc) begin
            ifc.done_i = 1'b1;
            for (int t = 0; t < 16; t++) ifc.status_i[t] = 1'(stc[t]);
        end
        @(posedge clk);
        done_t = $time;
        if (fa && qa.size() == 0) begin
            build(2, 2, sta);
            exp_a = rpt;
            push_exp(0);
        end
        if (fc && qc.size() == 0) begin
            build(16, 1, stc);
            push_exp(1);
        end
        #1;
        ifa.done_i = 1'b0;
        ifc.done_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((qa.size() != 0 || qc.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("report_timeout", int'(qa.size() == 0 && qc.size() == 0), 1);
        @(negedge clk);
    endtask

    task automatic chk_sent(input int exp_a_cnt, input int exp_c_cnt);
        chk("A_sent_count", sent_a, exp_a_cnt);
        chk("C_sent_count", sent_c, exp_c_cnt);
        sent_a = 0;
        sent_c = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sta[16];
        int stc[16];
        string lit_ok;
        byte   lit_q[$];

        ifa.done_i = 1'b0;
        ifc.done_i = 1'b0;
        for (int t = 0; t < 2; t++)  ifa.status_i[t] = '0;
        for (int t = 0; t < 16; t++) ifc.status_i[t] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_A_tx", int'(ifa.tx_o), 1);
        chk("rst_A_busy", int'(ifa.busy_o), 0);
        chk("rst_A_sent", int'(ifa.sent_o), 0);
        chk("rst_C_tx", int'(ifc.tx_o), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-ACK on A, full 16-line sweep on C.
        sta = '{default: 0};
        stc = '{default: 0};
        lit_ok = "T0:00\015\012T1:00\015\012OK\015\012";
        rx_first = 1'b1;
        fire(1'b1, 1'b1, sta, stc);
        foreach (lit_ok[i]) lit_q.push_back(byte'(lit_ok[i]));
        chk_bytes("model_all_ack", exp_a, lit_q);
        chk("C_report_len", rpt.size(), 100);
        wait_idle(6000);
        chk_rx_str("rx_all_ack", lit_ok);
        chk("first_fall_latency", int'((fall_t - done_t - 5) / 10), 2);
        chk_sent(1, 1);

        // NACK on transaction 1, byte 1.
        sta = '{default: 0};
        sta[1] = 2;
        fire(1'b1, 1'b0, sta, stc);
        wait_idle(2000);
        chk_rx_str("rx_nack", "T0:00\015\012T1:10\015\012NK\015\012");
        chk_sent(1, 0);

        // Re-trigger mid-report with different status: ignored.
        sta = '{default: 0};
        sta[0] = 1;
        fire(1'b1, 1'b0, sta, stc);
        repeat (100) @(posedge clk);
        sta[0] = 3;
        sta[1] = 3;
        fire(1'b1, 1'b0, sta, stc);
        wait_idle(2000);
        chk_rx_str("rx_retrigger", "T0:01\015\012T1:00\015\012NK\015\012");
        chk_sent(1, 0);

        // Reset during the third character.
        sta = '{default: 0};
        fire(1'b1, 1'b0, sta, stc);
        repeat (2 + 2 * 10 * B + 10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", int'(ifa.tx_o), 1);
        chk("async_rst_busy", int'(ifa.busy_o), 0);
        qa.delete();
        qc.delete();
        sent_a = 0;
        sent_c = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_sent", int'(ifa.sent_o), 0);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_sent(0, 0);
        sta[1] = 1;
        fire(1'b1, 1'b0, sta, stc);
        wait_idle(2000);
        chk_rx_str("rx_after_reset", "T0:00\015\012T1:01\015\012NK\015\012");
        chk_sent(1, 0);

        // Randomised reports on both DUTs.
        for (int it = 0; it < 5; it++) begin
            for (int t = 0; t < 16; t++) begin
                sta[t] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
                stc[t] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end
            if (it == 0) stc = '{default: 0};
            for (int t = 0; t < 2; t++)  ifa.status_i[t] = 2'($urandom_range(0, 3));
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            fire(1'b1, 1'b1, sta, stc);
            wait_idle(6000);
            chk_bytes("rx_random", rx_q, exp_a);
            chk_sent(1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
